fifo_readout_scheduler: RTL and testbench
=========================================

# fifo_readout_scheduler

Burst-limited round-robin scheduler that drains the per-source readout FIFOs (FE-I4 RX channels, TDC, TLU) into the single SRAM output FIFO. It sits between the first-word-fall-through source FIFOs and the SRAM FIFO write port. It locks one source per burst, honours a per-source hold request so multi-word records stay contiguous, and bounds every hold with a timeout.

## Interface
Parameters:
- WIDTH, 6, number of requesting sources (bit 0 = TLU, 1 = TDC, 2..5 = RX1..RX4)
- DSIZE, 32, data word width
- MAX_BURST, 16, maximum words per grant without hold (1..255)
- HOLD_TIMEOUT, 255, cycles a held-but-empty source may keep the lock (1..255)

Ports:
- BUS_CLK  in  1  the only clock
- BUS_RST_N  in  1  asynchronous, active-low reset
- ENABLE  in  WIDTH  per-source enable mask; 0 excludes the source from new selection
- WRITE_REQ  in  WIDTH  source FIFO not empty; its DATA_IN slice is valid
- HOLD_REQ  in  WIDTH  source requests to keep the lock after the current word
- DATA_IN  in  WIDTH*DSIZE  source i occupies bits [i*DSIZE +: DSIZE]
- READ_GRANT  out  WIDTH  one-hot pop strobe to the source FIFO (combinational)
- READY_IN  in  1  downstream accepts DATA_OUT this cycle
- WRITE_OUT  out  1  DATA_OUT valid
- DATA_OUT  out  DSIZE  registered output word
- CUR_SRC  out  3  index of the locked source (valid when BUSY)
- BUSY  out  1  state is LOCK
- TIMEOUT_ERR  out  1  sticky; set when a hold timeout fires, cleared only by reset

## Operation
- States: IDLE, LOCK.
- IDLE: candidate set C = WRITE_REQ & ENABLE. If C has any bit with HOLD_REQ set, pick its lowest index. Otherwise pick the first set bit of C, searching upward from (last+1) mod WIDTH with wrap. Register it as CUR_SRC, clear burst and timeout counters, go to LOCK. Stay in IDLE if C = 0.
- LOCK: READ_GRANT[CUR_SRC] = WRITE_REQ[CUR_SRC] & (!WRITE_OUT | READY_IN); all other grant bits are 0. Each grant loads DATA_IN[CUR_SRC] into DATA_OUT, sets WRITE_OUT, and increments the 8-bit burst counter.
- Output register: WRITE_OUT clears when READY_IN & !grant. One word moves per cycle maximum.
- LOCK -> IDLE, when HOLD_REQ[CUR_SRC] = 0 and one of the following holds:
  - the source is empty;
  - the burst count reached MAX_BURST;
  - ENABLE[CUR_SRC] dropped.
  On this transition, last <= CUR_SRC.
- HOLD_REQ[CUR_SRC] = 1 overrides MAX_BURST and the ENABLE drop.
- Hold timeout: while held and the source is empty, the timeout counter increments; it clears on any grant. At HOLD_TIMEOUT, set TIMEOUT_ERR and go to IDLE.
- Disabling a source mid-burst never truncates a held record.

## Timing
- Reset values:
  - state IDLE, last = WIDTH-1 (so source 0 is searched first)
  - DATA_OUT 0, WRITE_OUT 0, CUR_SRC 0, BUSY 0, TIMEOUT_ERR 0
  - counters 0, READ_GRANT 0
- Latency: IDLE selection costs 1 cycle. First grant comes in the cycle after selection. DATA_OUT/WRITE_OUT are valid the cycle after the grant.
- Back-to-back: with READY_IN held high, one word per cycle within a burst. Changing source costs 1 idle cycle.
- READY_IN low with WRITE_OUT high: no grant, DATA_OUT held stable.
- Simultaneous WRITE_OUT consumption and new grant in the same cycle: WRITE_OUT stays 1 and DATA_OUT updates.
- Reset asserted mid-burst: state and outputs return immediately to reset values. A word already in DATA_OUT is discarded.

## Configuration
- FIFO_READOUT_WORD_CNT_EN defined:
  - adds output WORD_CNT (WIDTH*16): per-source 16-bit counters that increment on each READ_GRANT and saturate at 16'hFFFF.
  - adds input CNT_CLEAR (1, synchronous clear of all counters; a grant in the same cycle does not count).
  - counters reset to 0.
- Macro undefined: the ports and counters are absent. Scheduling behaviour is identical.

## Structure
- Package fifo_readout_pkg holds:
  - the state enum (IDLE, LOCK)
  - the burst and timeout counter widths (8)
  - the word counter width (16)
  - the source index localparams (SRC_TLU = 0, SRC_TDC = 1, SRC_RX1 = 2)
- One sub-module: rr_pick. It is a combinational rotating priority encoder (request vector, start index -> index, valid) and is used for the IDLE selection.

## Test plan
- Round-robin: WIDTH=6, WRITE_REQ=6'b111111 continuously, HOLD_REQ=0, MAX_BURST=2, READY_IN=1 -> grants come in source order 0,0,1,1,2,2,...,5,5,0, with one gap cycle between sources.
- Burst limit: only source 3 requesting with 40 words queued, MAX_BURST=16 -> locks of 16, 16 and 8 words, separated by a single IDLE cycle each.
- Hold priority: source 2 mid-burst with HOLD_REQ[2]=1 through word 20, MAX_BURST=16, source 0 also requesting -> source 2 keeps the lock for all 20 words; then source 0 is granted.
- Hold timeout: HOLD_REQ[1]=1, source 1 empty, HOLD_TIMEOUT=10 -> TIMEOUT_ERR=1 ten cycles after emptying, then IDLE, then next source granted.
- Backpressure: READY_IN=0 for 5 cycles mid-burst -> no grants, DATA_OUT unchanged, no words lost or duplicated (scoreboard against the source queues).
- Reset mid-burst: BUS_RST_N low for 1 cycle during LOCK -> all outputs 0 at once; after release, source 0 is selected first. With FIFO_READOUT_WORD_CNT_EN defined, WORD_CNT also reads 0.

Source files
------------

// File: rtl/fifo_readout_scheduler_pkg.sv
// rtl/fifo_readout_scheduler_pkg.sv - shared types and widths for the readout scheduler
package fifo_readout_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_e;

  localparam int BURST_W = 8;
  localparam int TMO_W   = 8;
  localparam int WCNT_W  = 16;

  localparam int SRC_TLU = 0;
  localparam int SRC_TDC = 1;
  localparam int SRC_RX1 = 2;

endpackage

// File: rtl/fifo_readout_scheduler_if.sv
// rtl/fifo_readout_scheduler_if.sv - source-side and SRAM-side signals of the readout scheduler
interface fifo_readout_if #(
  parameter int WIDTH = 6,
  parameter int DSIZE = 32
);
  logic [WIDTH-1:0]       ENABLE;
  logic [WIDTH-1:0]       WRITE_REQ;
  logic [WIDTH-1:0]       HOLD_REQ;
  logic [WIDTH*DSIZE-1:0] DATA_IN;
  logic [WIDTH-1:0]       READ_GRANT;
  logic                   READY_IN;
  logic                   WRITE_OUT;
  logic [DSIZE-1:0]       DATA_OUT;
  logic [2:0]             CUR_SRC;
  logic                   BUSY;
  logic                   TIMEOUT_ERR;

  modport master (
    input  ENABLE, WRITE_REQ, HOLD_REQ, DATA_IN, READY_IN,
    output READ_GRANT, WRITE_OUT, DATA_OUT, CUR_SRC, BUSY, TIMEOUT_ERR
  );

  modport slave (
    output ENABLE, WRITE_REQ, HOLD_REQ, DATA_IN, READY_IN,
    input  READ_GRANT, WRITE_OUT, DATA_OUT, CUR_SRC, BUSY, TIMEOUT_ERR
  );
endinterface

// File: rtl/fifo_readout_scheduler_rr_pick.sv
// rtl/fifo_readout_scheduler_rr_pick.sv - rotating priority encoder: first set request at or after start_i
module rr_pick #(
  parameter int WIDTH = 6,
  parameter int IW    = 3
) (
  input  logic [WIDTH-1:0] req_i,
  input  logic [IW-1:0]    start_i,
  output logic [IW-1:0]    idx_o,
  output logic             valid_o
);

  int j;

  // Walk from the farthest offset back to start_i so the nearest request wins.
  always_comb begin
    idx_o = '0;
    j     = 0;
    for (int k = WIDTH - 1; k >= 0; k--) begin
      j = (int'(start_i) + k) % WIDTH;
      if (req_i[j]) begin
        idx_o = IW'(j);
      end
    end
  end

  assign valid_o = |req_i;

endmodule

// File: rtl/fifo_readout_scheduler.sv
// rtl/fifo_readout_scheduler.sv - burst-limited round-robin drain of source FIFOs into the SRAM FIFO
// Optional per-source word counters: FIFO_READOUT_WORD_CNT_EN
module fifo_readout_scheduler
  import fifo_readout_pkg::*;
#(
  parameter int WIDTH        = 6,
  parameter int DSIZE        = 32,
  parameter int MAX_BURST    = 16,
  parameter int HOLD_TIMEOUT = 255
) (
  input  logic                    BUS_CLK,
  input  logic                    BUS_RST_N,
`ifdef FIFO_READOUT_WORD_CNT_EN
  input  logic                    CNT_CLEAR,
  output logic [WIDTH*WCNT_W-1:0] WORD_CNT,
`endif
  fifo_readout_if.master          bus
);

  localparam int IW = 3;

  state_e             state_q;
  logic [IW-1:0]      cur_q, last_q;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [DSIZE-1:0]   dout_q, data_cur;
  logic               wout_q, err_q;

  logic               req_cur, hold_cur, en_cur, grant_cur, tmo_hit, leave;
  logic [WIDTH-1:0]   cand, grant;
  logic [IW-1:0]      start_idx, rr_idx, hold_idx;
  logic               rr_vld, hold_vld;

  assign cand      = bus.WRITE_REQ & bus.ENABLE;
  assign start_idx = (int'(last_q) == WIDTH - 1) ? '0 : last_q + 1'b1;

  rr_pick #(.WIDTH(WIDTH), .IW(IW)) u_rr_pick (
    .req_i   (cand),
    .start_i (start_idx),
    .idx_o   (rr_idx),
    .valid_o (rr_vld)
  );

  // Held candidates preempt the rotation; lowest index wins among them.
  rr_pick #(.WIDTH(WIDTH), .IW(IW)) u_hold_pick (
    .req_i   (cand & bus.HOLD_REQ),
    .start_i (IW'(SRC_TLU)),
    .idx_o   (hold_idx),
    .valid_o (hold_vld)
  );

  always_comb begin
    req_cur  = 1'b0;
    hold_cur = 1'b0;
    en_cur   = 1'b0;
    data_cur = '0;
    grant    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (int'(cur_q) == i) begin
        req_cur  = bus.WRITE_REQ[i];
        hold_cur = bus.HOLD_REQ[i];
        en_cur   = bus.ENABLE[i];
        data_cur = bus.DATA_IN[i*DSIZE +: DSIZE];
      end
    end

    grant_cur = (state_q == LOCK) && req_cur && (!wout_q || bus.READY_IN);
    for (int i = 0; i < WIDTH; i++) begin
      grant[i] = grant_cur && (int'(cur_q) == i);
    end

    burst_d = burst_q;
    if (grant_cur && (burst_q != '1)) begin
      burst_d = burst_q + 1'b1;
    end

    tmo_d   = grant_cur ? '0 : tmo_q;
    tmo_hit = 1'b0;
    if (hold_cur && !req_cur) begin
      tmo_d   = tmo_q + 1'b1;
      tmo_hit = int'(tmo_d) >= HOLD_TIMEOUT;
    end

    // The word granted this cycle is judged with its own hold flag, so a record is never cut.
    leave = hold_cur ? tmo_hit
                     : (!req_cur || !en_cur || int'(burst_d) >= MAX_BURST);
  end

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      state_q <= IDLE;
      cur_q   <= '0;
      last_q  <= IW'(WIDTH - 1);
      burst_q <= '0;
      tmo_q   <= '0;
      dout_q  <= '0;
      wout_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (grant_cur) begin
        dout_q <= data_cur;
        wout_q <= 1'b1;
      end else if (bus.READY_IN) begin
        wout_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (rr_vld) begin
            state_q <= LOCK;
            cur_q   <= hold_vld ? hold_idx : rr_idx;
            burst_q <= '0;
            tmo_q   <= '0;
          end
        end
        LOCK: begin
          burst_q <= burst_d;
          tmo_q   <= tmo_d;
          if (leave) begin
            state_q <= IDLE;
            last_q  <= cur_q;
            if (tmo_hit) begin
              err_q <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.READ_GRANT  = grant;
  assign bus.DATA_OUT    = dout_q;
  assign bus.WRITE_OUT   = wout_q;
  assign bus.CUR_SRC     = cur_q;
  assign bus.BUSY        = (state_q == LOCK);
  assign bus.TIMEOUT_ERR = err_q;

`ifdef FIFO_READOUT_WORD_CNT_EN
  logic [WCNT_W-1:0] wcnt_q [WIDTH];

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      for (int i = 0; i < WIDTH; i++) begin
        wcnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (CNT_CLEAR) begin
          wcnt_q[i] <= '0;
        end else if (grant[i] && (wcnt_q[i] != '1)) begin
          wcnt_q[i] <= wcnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    WORD_CNT = '0;
    for (int i = 0; i < WIDTH; i++) begin
      WORD_CNT[i*WCNT_W +: WCNT_W] = wcnt_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_fifo_readout_scheduler.sv
// tb/tb_fifo_readout_scheduler.sv - randomized bench with queue-based source model for fifo_readout_scheduler
module tb_fifo_readout_scheduler;

  localparam int W  = 6;
  localparam int DW = 32;
  localparam int MB = 4;
  localparam int TO = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_readout_if #(.WIDTH(W), .DSIZE(DW)) bus();

`ifdef FIFO_READOUT_WORD_CNT_EN
  logic            cnt_clear = 1'b0;
  logic [W*16-1:0] word_cnt;
`endif

  fifo_readout_scheduler #(
    .WIDTH(W), .DSIZE(DW), .MAX_BURST(MB), .HOLD_TIMEOUT(TO)
  ) dut (
    .BUS_CLK   (clk),
    .BUS_RST_N (rst_n),
`ifdef FIFO_READOUT_WORD_CNT_EN
    .CNT_CLEAR (cnt_clear),
    .WORD_CNT  (word_cnt),
`endif
    .bus       (bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int seq = 0;
  int err_seen = -1;

  logic [32:0]  srcq [W][$];
  logic [W-1:0] en, hold_empty;
  logic         ready;

  bit         m_lock, m_wout, m_err;
  int         m_cur, m_last, m_burst, m_tmo;
  logic [DW-1:0] m_dout;

  int g_src[$];
  int g_cyc[$];
  int runs[$];
  int exp_runs[3] = '{4, 4, 2};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int onehot_idx(input logic [W-1:0] v);
    int r = -1;
    for (int i = 0; i < W; i++) if (v[i]) r = i;
    return r;
  endfunction

  function automatic bit pending();
    bit p = m_lock || m_wout;
    for (int i = 0; i < W; i++) if (srcq[i].size() > 0) p = 1'b1;
    return p;
  endfunction

  task automatic model_reset();
    m_lock = 0; m_cur = 0; m_last = W - 1; m_burst = 0; m_tmo = 0;
    m_dout = '0; m_wout = 0; m_err = 0;
  endtask

  // Words carry the hold flag in bit 32; a record holds on every word but its last.
  task automatic push_words(input int s, input int n, input bit rec);
    for (int k = 0; k < n; k++) begin
      srcq[s].push_back({rec && (k < n - 1), 8'(s), 24'(seq)});
      seq++;
    end
  endtask

  task automatic drive();
    for (int i = 0; i < W; i++) begin
      if (srcq[i].size() > 0) begin
        bus.WRITE_REQ[i] = 1'b1;
        bus.HOLD_REQ[i]  = srcq[i][0][32];
        bus.DATA_IN[i*DW +: DW] = srcq[i][0][31:0];
      end else begin
        bus.WRITE_REQ[i] = 1'b0;
        bus.HOLD_REQ[i]  = hold_empty[i];
        bus.DATA_IN[i*DW +: DW] = $urandom;
      end
    end
    bus.ENABLE   = en;
    bus.READY_IN = ready;
  endtask

  // One clock: check registered outputs, drive, check grant, advance the model.
  task automatic step();
    int c, pick, gi;
    bit r, h, g, leave;
    logic [W-1:0] cand, hcand, exp_g;
    chk("write_out", bus.WRITE_OUT, m_wout);
    chk("data_out", bus.DATA_OUT, m_dout);
    chk("busy", bus.BUSY, m_lock);
    chk("cur_src", bus.CUR_SRC, m_cur);
    chk("timeout_err", bus.TIMEOUT_ERR, m_err);
    if (bus.TIMEOUT_ERR === 1'b1 && err_seen < 0) err_seen = cyc;
    drive();
    #1;
    c = m_cur;
    r = srcq[c].size() > 0;
    h = r ? srcq[c][0][32] : hold_empty[c];
    g = m_lock && r && (!m_wout || ready);
    exp_g = '0;
    if (g) exp_g[c] = 1'b1;
    chk("read_grant", bus.READ_GRANT, exp_g);
    gi = onehot_idx(bus.READ_GRANT);
    if (gi >= 0) begin
      g_src.push_back(gi);
      g_cyc.push_back(cyc);
    end
    if (g) begin
      m_dout = srcq[c][0][31:0];
      m_wout = 1;
      void'(srcq[c].pop_front());
      if (m_burst < 255) m_burst++;
      m_tmo = 0;
    end else if (ready) begin
      m_wout = 0;
    end
    if (!m_lock) begin
      cand = '0; hcand = '0; pick = -1;
      for (int i = 0; i < W; i++) begin
        if (srcq[i].size() > 0 && en[i]) begin
          cand[i] = 1'b1;
          hcand[i] = srcq[i][0][32];
        end
      end
      for (int i = W - 1; i >= 0; i--) if (hcand[i]) pick = i;
      if (pick < 0)
        for (int k = W; k >= 1; k--) if (cand[(m_last + k) % W]) pick = (m_last + k) % W;
      if (pick >= 0) begin
        m_lock = 1; m_cur = pick; m_burst = 0; m_tmo = 0;
      end
    end else begin
      leave = 0;
      if (!h) begin
        leave = !r || !en[c] || (m_burst >= MB);
      end else if (!r) begin
        m_tmo++;
        if (m_tmo >= TO) begin
          m_err = 1;
          leave = 1;
        end
      end
      if (leave) begin
        m_lock = 0;
        m_last = c;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic run_until_grants(input int n, input int bound);
    int k = 0;
    while (g_src.size() < n && k < bound) begin
      step();
      k++;
    end
    chk("grants_reached", g_src.size() >= n, 1);
  endtask

  task automatic drain(input int bound);
    int k = 0;
    while (pending() && k < bound) begin
      step();
      k++;
    end
    chk("drain_done", pending(), 0);
  endtask

  task automatic clear_log();
    g_src.delete();
    g_cyc.delete();
  endtask

  initial begin
    int base, s;
    en = '1; ready = 1'b1; hold_empty = '0;
    model_reset();
    drive();
    repeat (3) @(negedge clk);
    chk("rst_write_out", bus.WRITE_OUT, 0);
    chk("rst_data_out", bus.DATA_OUT, 0);
    chk("rst_busy", bus.BUSY, 0);
    chk("rst_cur_src", bus.CUR_SRC, 0);
    chk("rst_timeout_err", bus.TIMEOUT_ERR, 0);
    chk("rst_read_grant", bus.READ_GRANT, 0);
    rst_n = 1'b1;

    // Round robin with every source full: 0x4,1x4,...,5x4,0, gap of one idle cycle between sources.
    clear_log();
    for (int i = 0; i < W; i++) push_words(i, 8, 0);
    run_until_grants(25, 200);
    for (int n = 0; n < 25 && n < g_src.size(); n++) begin
      chk("rr_src", g_src[n], (n / MB) % W);
      if (n > 0) chk("rr_gap", g_cyc[n] - g_cyc[n-1], (n % MB == 0) ? 2 : 1);
    end
    drain(600);

    // Burst limit: 10 words on source 3 -> locks of 4, 4, 2.
    clear_log();
    push_words(3, 10, 0);
    drain(200);
    runs.delete();
    for (int n = 0; n < g_src.size(); n++) begin
      if (n == 0 || g_cyc[n] - g_cyc[n-1] != 1) runs.push_back(1);
      else runs[runs.size()-1]++;
    end
    chk("burst_runs", runs.size(), 3);
    for (int i = 0; i < 3 && i < runs.size(); i++) chk("burst_len", runs[i], exp_runs[i]);
    if (g_cyc.size() == 10) begin
      chk("burst_gap1", g_cyc[4] - g_cyc[3], 2);
      chk("burst_gap2", g_cyc[8] - g_cyc[7], 2);
    end

    // Hold: a 12-word record on source 2 outlasts the burst limit, then source 0.
    clear_log();
    push_words(2, 12, 1);
    push_words(0, 3, 0);
    drain(200);
    chk("hold_count", g_src.size(), 15);
    for (int n = 0; n < 15 && n < g_src.size(); n++) chk("hold_src", g_src[n], (n < 12) ? 2 : 0);
    if (g_src.size() == 15) begin
      chk("hold_contig", g_cyc[11] - g_cyc[0], 11);
      chk("hold_switch", g_cyc[12] - g_cyc[11], 2);
    end

    // Hold timeout: source 1 keeps holding after emptying.
    clear_log();
    err_seen = -1;
    hold_empty[1] = 1'b1;
    push_words(1, 2, 1);
    push_words(4, 2, 0);
    drain(200);
    hold_empty[1] = 1'b0;
    chk("tmo_count", g_src.size(), 4);
    if (g_src.size() == 4) begin
      chk("tmo_src0", g_src[1], 1);
      chk("tmo_next_src", g_src[2], 4);
      chk("tmo_err_delay", err_seen - g_cyc[1], TO + 1);
      chk("tmo_next_grant", g_cyc[2] - g_cyc[1], TO + 2);
    end

    // Backpressure mid-burst.
    clear_log();
    base = seq;
    push_words(5, 8, 0);
    run_until_grants(2, 20);
    ready = 1'b0;
    repeat (5) step();
    chk("bp_no_grant", g_src.size(), 2);
    chk("bp_hold_data", bus.DATA_OUT, {8'd5, 24'(base + 1)});
    chk("bp_write_out", bus.WRITE_OUT, 1);
    ready = 1'b1;
    drain(200);
    chk("bp_total", g_src.size(), 8);

    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        s = $urandom_range(0, W - 1);
        if (srcq[s].size() < 12) push_words(s, $urandom_range(1, 6), 1'($urandom_range(0, 1)));
      end
      ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) begin
        s = $urandom_range(0, W - 1);
        en[s] = ~en[s];
      end
      if ($urandom_range(0, 63) == 0) hold_empty = W'($urandom & $urandom & $urandom);
      step();
    end
    ready = 1'b1; en = '1; hold_empty = '0;
    drain(2000);

    // Reset mid-burst.
    clear_log();
    push_words(4, 8, 0);
    run_until_grants(2, 20);
    rst_n = 1'b0;
    #1;
    chk("mrst_write_out", bus.WRITE_OUT, 0);
    chk("mrst_data_out", bus.DATA_OUT, 0);
    chk("mrst_busy", bus.BUSY, 0);
    chk("mrst_cur_src", bus.CUR_SRC, 0);
    chk("mrst_timeout_err", bus.TIMEOUT_ERR, 0);
    chk("mrst_read_grant", bus.READ_GRANT, 0);
`ifdef FIFO_READOUT_WORD_CNT_EN
    chk("mrst_word_cnt", word_cnt == '0, 1);
`endif
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    clear_log();
    push_words(0, 2, 0);
    drain(200);
    chk("post_rst_count", g_src.size(), 8);
    if (g_src.size() > 0) chk("post_rst_first", g_src[0], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

endmodule
